i_decode: RTL and testbench
===========================

# i_decode

Instruction-decode stage of the five-stage MIPS pipeline; it is the consumer of the fetch stage's IF/ID buffer and the producer of the fetch stage's branch controls (PCSrc, BrDest). It holds the 32-entry register file with a write-back port, decodes the opcode into control bits, resolves beq early, and detects load-use and branch-operand hazards. The ID/EX pipeline register lives inside the block and inserts bubbles on stall.

## Interface
- WORD, 32, datapath width in bits.
- NREG, 32, register-file entries; address width is 5.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- IR_id  in  WORD  instruction from the IF/ID buffer.
- nPC_id  in  WORD  PC+STEP from the IF/ID buffer.
- RegWrite_wb  in  1  write-back enable.
- WriteReg_wb  in  5  write-back register number.
- WriteData_wb  in  WORD  write-back data.
- MemRead_mem, WriteReg_mem  in  1, 5  load in the MEM stage and its destination register.
- PCSrc  out  1  take branch; feeds the fetch mux select.
- BrDest  out  WORD  branch target; feeds the fetch mux B input.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_if  out  1  squash the IF/ID entry on the next edge; equals PCSrc.
- nPC_ex, rd1_ex, rd2_ex, imm_ex  out  WORD  registered ID/EX data.
- rs_ex, rt_ex, rd_ex  out  5  registered register fields.
- RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex  out  1  registered control.
- ALUOp_ex  out  2  registered ALU class.

## Operation
- Fields: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=sign-extended IR[15:0].
- Decode, using RegDst/ALUSrc/MemRead/MemWrite/MemtoReg/RegWrite/Branch and ALUOp:
  - R-type, 0x00: 1/0/0/0/0/1/0, ALUOp=10.
  - lw, 0x23: 0/1/1/0/1/1/0, ALUOp=00.
  - sw, 0x2B: x/1/0/1/x/0/0, ALUOp=00; drive 0 for the x bits.
  - beq, 0x04: 0/0/0/0/0/0/1, ALUOp=01.
  - addi, 0x08: 0/1/0/0/0/1/0, ALUOp=00.
  - Any other opcode: all control bits 0, i.e. a NOP.
- Register file:
  - Written on the rising edge when RegWrite_wb=1 and WriteReg_wb≠0.
  - Register 0 always reads 0.
  - Reads are combinational with write-through: if the write-back writes this cycle to a nonzero register equal to rs or rt, that read returns WriteData_wb.
- The instruction uses rt when op is R-type, sw, or beq.
- dest_ex = RegDst_ex ? rd_ex : rt_ex.
- Load-use hazard: MemRead_ex=1, rt_ex≠0, and rt_ex equals rs, or equals rt when the instruction uses rt.
- Branch hazard, only when op=beq, on either of:
  - RegWrite_ex=1, dest_ex≠0, and dest_ex∈{rs,rt}.
  - MemRead_mem=1, WriteReg_mem≠0, and WriteReg_mem∈{rs,rt}.
- stall = load-use hazard OR branch hazard.
- Branch: BrDest = nPC_id + imm, modulo 2^WORD; the word-addressed PC means no shift. PCSrc = Branch AND (rd1==rd2) AND NOT stall.
- ID/EX update on each rising edge:
  - stall=1: all control fields load 0 (bubble); data fields are don't-care but load the current values.
  - Otherwise: all fields load the decoded values.
- The ID/EX register has no enable. It is never held; it always advances.

## Timing
- Reset (reset=0), asynchronous:
  - All ID/EX outputs and all register-file entries become 0.
  - Combinational outputs then follow IR_id; with IR_id=0 (sll $0): PCSrc=0, stall=0, flush_if=0.
- PCSrc, BrDest, stall, and flush_if are combinational and valid in the same cycle as IR_id.
- ID/EX outputs have 1-cycle latency.
- Stall duration:
  - A load-use stall lasts exactly 1 cycle, because the bubble clears MemRead_ex.
  - A beq after an ALU op stalls 1 cycle.
  - A beq directly after lw stalls 2 cycles: first on EX, then on MEM.
- Write-back and read in the same cycle to the same register: the read returns the new data.
- Write to $0 is ignored.
- Reset asserted mid-operation clears state immediately. The first edge after release captures a normal decode.

## Test plan
- Reset with IR_id=0 → all ID/EX outputs 0, PCSrc=0, stall=0; release, then read $5 → 0.
- WB writes 0x1234 to $8 while IR_id=addi $9,$8,-1 (0x2109FFFF) → next edge: rd1_ex=0x1234, imm_ex=0xFFFFFFFF, ALUSrc_ex=1, RegWrite_ex=1, rt_ex=9.
- lw $2,0($1) followed by add $3,$2,$4 → stall=1 for one cycle, the ID/EX bubble has RegWrite_ex=0, and the add issues on the following edge.
- $1=$2=7, nPC_id=0x10, beq $1,$2,+5 with no hazard → PCSrc=1, flush_if=1, BrDest=0x15; with $2=8 → PCSrc=0.
- lw $1 then beq $1,$0 → stall high for 2 consecutive cycles and PCSrc=0 throughout; resolves in the third cycle.
- WB writes 0xFFFF to $0 → a subsequent read of $0 returns 0.

Source files
------------

// File: rtl/i_decode.sv
// Instruction-decode stage: register file with write-through, opcode decode,
// early beq resolution, load-use / branch-operand hazard detection, ID/EX register.
module i_decode #(
    parameter int WORD = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] IR_id,
    input  logic [WORD-1:0] nPC_id,
    input  logic            RegWrite_wb,
    input  logic [4:0]      WriteReg_wb,
    input  logic [WORD-1:0] WriteData_wb,
    input  logic            MemRead_mem,
    input  logic [4:0]      WriteReg_mem,
    output logic            PCSrc,
    output logic [WORD-1:0] BrDest,
    output logic            stall,
    output logic            flush_if,
    output logic [WORD-1:0] nPC_ex,
    output logic [WORD-1:0] rd1_ex,
    output logic [WORD-1:0] rd2_ex,
    output logic [WORD-1:0] imm_ex,
    output logic [4:0]      rs_ex,
    output logic [4:0]      rt_ex,
    output logic [4:0]      rd_ex,
    output logic            RegDst_ex,
    output logic            ALUSrc_ex,
    output logic            MemRead_ex,
    output logic            MemWrite_ex,
    output logic            MemtoReg_ex,
    output logic            RegWrite_ex,
    output logic [1:0]      ALUOp_ex
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [WORD-1:0] imm;

    assign op  = IR_id[31:26];
    assign rs  = IR_id[25:21];
    assign rt  = IR_id[20:16];
    assign rd  = IR_id[15:11];
    assign imm = {{(WORD-16){IR_id[15]}}, IR_id[15:0]};

    // Register file; entry 0 is never written so it stays at its reset value.
    logic [WORD-1:0] rf_reg [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (RegWrite_wb && (WriteReg_wb != 5'd0)) begin
            rf_reg[WriteReg_wb] <= WriteData_wb;
        end
    end

    logic [WORD-1:0] rd1;
    logic [WORD-1:0] rd2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs != 5'd0) begin
            rd1 = (RegWrite_wb && (WriteReg_wb == rs)) ? WriteData_wb : rf_reg[rs];
        end
        if (rt != 5'd0) begin
            rd2 = (RegWrite_wb && (WriteReg_wb == rt)) ? WriteData_wb : rf_reg[rt];
        end
    end

    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;

    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        case (op)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    logic       uses_rt;
    logic [4:0] dest_ex;
    logic       load_use;
    logic       br_hazard_ex;
    logic       br_hazard_mem;

    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    assign dest_ex = RegDst_ex ? rd_ex : rt_ex;

    assign load_use = MemRead_ex && (rt_ex != 5'd0) &&
                      ((rt_ex == rs) || (uses_rt && (rt_ex == rt)));

    // beq compares in ID, so it must wait for any producer still in EX or a load in MEM.
    assign br_hazard_ex  = RegWrite_ex && (dest_ex != 5'd0) &&
                           ((dest_ex == rs) || (dest_ex == rt));
    assign br_hazard_mem = MemRead_mem && (WriteReg_mem != 5'd0) &&
                           ((WriteReg_mem == rs) || (WriteReg_mem == rt));

    assign stall    = load_use || (branch && (br_hazard_ex || br_hazard_mem));
    assign BrDest   = nPC_id + imm;
    assign PCSrc    = branch && (rd1 == rd2) && !stall;
    assign flush_if = PCSrc;

    // ID/EX register always advances; a stall only zeroes the control fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nPC_ex      <= '0;
            rd1_ex      <= '0;
            rd2_ex      <= '0;
            imm_ex      <= '0;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
            RegDst_ex   <= 1'b0;
            ALUSrc_ex   <= 1'b0;
            MemRead_ex  <= 1'b0;
            MemWrite_ex <= 1'b0;
            MemtoReg_ex <= 1'b0;
            RegWrite_ex <= 1'b0;
            ALUOp_ex    <= 2'b00;
        end else begin
            nPC_ex      <= nPC_id;
            rd1_ex      <= rd1;
            rd2_ex      <= rd2;
            imm_ex      <= imm;
            rs_ex       <= rs;
            rt_ex       <= rt;
            rd_ex       <= rd;
            RegDst_ex   <= reg_dst    && !stall;
            ALUSrc_ex   <= alu_src    && !stall;
            MemRead_ex  <= mem_read   && !stall;
            MemWrite_ex <= mem_write  && !stall;
            MemtoReg_ex <= mem_to_reg && !stall;
            RegWrite_ex <= reg_write  && !stall;
            ALUOp_ex    <= stall ? 2'b00 : alu_op;
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: ID/EX expectations go through a scoreboard queue,
// combinational outputs are compared inline in each scenario task.
module tb_i_decode;

    logic        clk;
    logic        reset;
    logic [31:0] IR_id;
    logic [31:0] nPC_id;
    logic        RegWrite_wb;
    logic [4:0]  WriteReg_wb;
    logic [31:0] WriteData_wb;
    logic        MemRead_mem;
    logic [4:0]  WriteReg_mem;
    logic        PCSrc;
    logic [31:0] BrDest;
    logic        stall;
    logic        flush_if;
    logic [31:0] nPC_ex, rd1_ex, rd2_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex;
    logic [1:0]  ALUOp_ex;

    i_decode #(.WORD(32), .NREG(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .IR_id        (IR_id),
        .nPC_id       (nPC_id),
        .RegWrite_wb  (RegWrite_wb),
        .WriteReg_wb  (WriteReg_wb),
        .WriteData_wb (WriteData_wb),
        .MemRead_mem  (MemRead_mem),
        .WriteReg_mem (WriteReg_mem),
        .PCSrc        (PCSrc),
        .BrDest       (BrDest),
        .stall        (stall),
        .flush_if     (flush_if),
        .nPC_ex       (nPC_ex),
        .rd1_ex       (rd1_ex),
        .rd2_ex       (rd2_ex),
        .imm_ex       (imm_ex),
        .rs_ex        (rs_ex),
        .rt_ex        (rt_ex),
        .rd_ex        (rd_ex),
        .RegDst_ex    (RegDst_ex),
        .ALUSrc_ex    (ALUSrc_ex),
        .MemRead_ex   (MemRead_ex),
        .MemWrite_ex  (MemWrite_ex),
        .MemtoReg_ex  (MemtoReg_ex),
        .RegWrite_ex  (RegWrite_ex),
        .ALUOp_ex     (ALUOp_ex)
    );

    // Control order: {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp[1:0]}
    localparam logic [7:0] CTRL_R    = 8'b1_0_0_0_0_1_10;
    localparam logic [7:0] CTRL_LW   = 8'b0_1_1_0_1_1_00;
    localparam logic [7:0] CTRL_SW   = 8'b0_1_0_1_0_0_00;
    localparam logic [7:0] CTRL_BEQ  = 8'b0_0_0_0_0_0_01;
    localparam logic [7:0] CTRL_ADDI = 8'b0_1_0_0_0_1_00;
    localparam logic [7:0] CTRL_NONE = 8'b0_0_0_0_0_0_00;

    typedef struct {
        int          tag;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    logic [150:0] mon_got;
    logic [150:0] mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

    // Drive one instruction (plus WB/MEM side inputs) and queue the ID/EX contents it must produce.
    task automatic issue(input logic [31:0] ir, input logic [31:0] npc,
                         input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                         input logic mrm, input logic [4:0] wrm,
                         input logic [7:0] ctrl, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        @(negedge clk);
        IR_id        = ir;
        nPC_id       = npc;
        RegWrite_wb  = wbe;
        WriteReg_wb  = wbr;
        WriteData_wb = wbd;
        MemRead_mem  = mrm;
        WriteReg_mem = wrm;
        #1;
        e.tag  = n_txn;
        n_txn++;
        e.npc  = npc;
        e.rd1  = e1;
        e.rd2  = e2;
        e.imm  = {{16{ir[15]}}, ir[15:0]};
        e.rs   = ir[25:21];
        e.rt   = ir[20:16];
        e.rd   = ir[15:11];
        e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    // Scoreboard pop: each queued expectation is due one edge after it was driven.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e   = sb.pop_front();
            mon_got = {nPC_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex,
                       RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex, ALUOp_ex};
            mon_exp = {mon_e.npc, mon_e.rd1, mon_e.rd2, mon_e.imm, mon_e.rs, mon_e.rt, mon_e.rd, mon_e.ctrl};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL idex txn %0d got %h required %h", mon_e.tag, mon_got, mon_exp);
            end else begin
                $display("txn %0d: npc=%h rd1=%h rd2=%h imm=%h ctrl=%b", mon_e.tag, nPC_ex, rd1_ex, rd2_ex,
                         imm_ex, mon_e.ctrl);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        IR_id = '0; nPC_id = '0;
        RegWrite_wb = 1'b0; WriteReg_wb = '0; WriteData_wb = '0;
        MemRead_mem = 1'b0; WriteReg_mem = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({nPC_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex, RegDst_ex, ALUSrc_ex, MemRead_ex,
             MemWrite_ex, MemtoReg_ex, RegWrite_ex, ALUOp_ex} !== 151'd0) begin
            n_fail++;
            $display("FAIL reset_idex got rd1=%h rt=%h regwrite=%b required all zero", rd1_ex, rt_ex, RegWrite_ex);
        end
        n_checks++;
        if ({PCSrc, stall, flush_if} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_comb got pcsrc/stall/flush=%b required 000", {PCSrc, stall, flush_if});
        end
        reset = 1'b1;
        issue(rtype(5'd5, 5'd0, 5'd1), 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read5_stall got %b required 0", stall);
        end
    endtask

    task automatic test_writeback();
        issue(32'h2109FFFF, 32'h8, 1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, CTRL_ADDI, 32'h1234, 32'h0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_stall got %b required 0", stall);
        end
        issue(rtype(5'd8, 5'd8, 5'd10), 32'hC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h1234, 32'h1234);
    endtask

    task automatic test_load_use();
        issue(itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_LW, 32'h0, 32'h0);
        issue(rtype(5'd2, 5'd4, 5'd3), 32'h14, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_NONE, 32'h0, 32'h0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_stall got %b required 1", stall);
        end
        issue(rtype(5'd2, 5'd4, 5'd3), 32'h14, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_release got %b required 0", stall);
        end
        // addi does not read rt, so a matching rt must not stall.
        issue(itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h18, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_LW, 32'h0, 32'h0);
        issue(itype(6'h08, 5'd0, 5'd2, 16'h1), 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_ADDI, 32'h0, 32'h0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_rt_nostall got %b required 0", stall);
        end
    endtask

    task automatic test_branch();
        issue(32'h0, 32'h0, 1'b1, 5'd1, 32'h7, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        issue(32'h0, 32'h0, 1'b1, 5'd2, 32'h7, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        issue(itype(6'h04, 5'd1, 5'd2, 16'd5), 32'h10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_BEQ, 32'h7, 32'h7);
        n_checks++;
        if ({PCSrc, flush_if, stall} !== 3'b110) begin
            n_fail++;
            $display("FAIL beq_taken got pcsrc/flush/stall=%b required 110", {PCSrc, flush_if, stall});
        end
        n_checks++;
        if (BrDest !== 32'h15) begin
            n_fail++;
            $display("FAIL beq_dest got %h required 00000015", BrDest);
        end
        issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFC), 32'h10, 1'b1, 5'd2, 32'h8, 1'b0, 5'd0, CTRL_BEQ, 32'h7, 32'h8);
        n_checks++;
        if ({PCSrc, flush_if} !== 2'b00) begin
            n_fail++;
            $display("FAIL beq_not_taken got pcsrc/flush=%b required 00", {PCSrc, flush_if});
        end
        n_checks++;
        if (BrDest !== 32'hC) begin
            n_fail++;
            $display("FAIL beq_negdest got %h required 0000000c", BrDest);
        end
        issue(rtype(5'd3, 5'd4, 5'd1), 32'h14, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        issue(itype(6'h04, 5'd1, 5'd2, 16'd5), 32'h18, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_NONE, 32'h7, 32'h8);
        n_checks++;
        if ({stall, PCSrc} !== 2'b10) begin
            n_fail++;
            $display("FAIL beq_after_alu got stall/pcsrc=%b required 10", {stall, PCSrc});
        end
        issue(itype(6'h04, 5'd1, 5'd2, 16'd5), 32'h18, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_BEQ, 32'h7, 32'h8);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_after_alu_release got %b required 0", stall);
        end
    endtask

    task automatic test_lw_beq();
        issue(itype(6'h23, 5'd3, 5'd1, 16'h0), 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_LW, 32'h0, 32'h7);
        issue(itype(6'h04, 5'd1, 5'd0, 16'd2), 32'h20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_NONE, 32'h7, 32'h0);
        n_checks++;
        if ({stall, PCSrc} !== 2'b10) begin
            n_fail++;
            $display("FAIL lwbeq_cycle1 got stall/pcsrc=%b required 10", {stall, PCSrc});
        end
        issue(itype(6'h04, 5'd1, 5'd0, 16'd2), 32'h20, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, CTRL_NONE, 32'h7, 32'h0);
        n_checks++;
        if ({stall, PCSrc} !== 2'b10) begin
            n_fail++;
            $display("FAIL lwbeq_cycle2 got stall/pcsrc=%b required 10", {stall, PCSrc});
        end
        // Load data arrives through write-back in the same cycle the beq finally reads it.
        issue(itype(6'h04, 5'd1, 5'd0, 16'd2), 32'h20, 1'b1, 5'd1, 32'h0, 1'b0, 5'd0, CTRL_BEQ, 32'h0, 32'h0);
        n_checks++;
        if ({stall, PCSrc} !== 2'b01) begin
            n_fail++;
            $display("FAIL lwbeq_cycle3 got stall/pcsrc=%b required 01", {stall, PCSrc});
        end
        n_checks++;
        if (BrDest !== 32'h22) begin
            n_fail++;
            $display("FAIL lwbeq_dest got %h required 00000022", BrDest);
        end
    endtask

    task automatic test_misc_decode();
        issue(32'h0, 32'h24, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
        issue(itype(6'h04, 5'd0, 5'd0, 16'd3), 32'h30, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_BEQ, 32'h0, 32'h0);
        n_checks++;
        if (BrDest !== 32'h33) begin
            n_fail++;
            $display("FAIL r0_beq_dest got %h required 00000033", BrDest);
        end
        issue(itype(6'h2B, 5'd1, 5'd2, 16'd4), 32'h34, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_SW, 32'h0, 32'h8);
        issue(itype(6'h3F, 5'd2, 5'd2, 16'h0), 32'h38, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_NONE, 32'h8, 32'h8);
        n_checks++;
        if ({stall, PCSrc} !== 2'b00) begin
            n_fail++;
            $display("FAIL unknown_op got stall/pcsrc=%b required 00", {stall, PCSrc});
        end
        issue(rtype(5'd0, 5'd0, 5'd3), 32'h3C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        IR_id = itype(6'h04, 5'd2, 5'd0, 16'd1);
        nPC_id = 32'h40;
        RegWrite_wb = 1'b0; MemRead_mem = 1'b0;
        #1;
        n_checks++;
        if (PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL prereset_pcsrc got %b required 0", PCSrc);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({nPC_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex, RegDst_ex, ALUSrc_ex, MemRead_ex,
             MemWrite_ex, MemtoReg_ex, RegWrite_ex, ALUOp_ex} !== 151'd0) begin
            n_fail++;
            $display("FAIL midreset_idex got npc=%h rs=%h required all zero", nPC_ex, rs_ex);
        end
        n_checks++;
        if ({PCSrc, BrDest} !== {1'b1, 32'h41}) begin
            n_fail++;
            $display("FAIL midreset_rfclear got pcsrc=%b dest=%h required 1 00000041", PCSrc, BrDest);
        end
        reset = 1'b1;
        issue(rtype(5'd2, 5'd0, 5'd4), 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, CTRL_R, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_load_use();
        test_branch();
        test_lw_beq();
        test_misc_decode();
        test_mid_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
